// File: rtl/updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// updown_sweep_ctrl
//
// Sequencer that drives an external N-bit up/down counter through triangle
// sweeps: LO up to HI, back down to LO, repeated REPS times. The counter has
// no enable input, so whenever the controller wants the count to stand still
// it reloads the counter with its own current value (LD=1, DIN=CNT).
//
// Ports:
//   clk        rising-edge clock
//   RESET      asynchronous, active-high reset
//   START      request a sweep run (only looked at in IDLE)
//   ABORT      stop the current run, no DONE
//   LO, HI     sweep floor / ceiling (N bits, LO < HI required)
//   REPS       number of full up+down sweeps (REP_W bits, non-zero)
//   CNT        current counter value
//   CNTR_RST   synchronous clear to the counter (pulses after reset)
//   CNTR_LD    counter load strobe
//   CNTR_UP    counter direction (1 = up)
//   CNTR_DIN   counter load value
//   BUSY       run in progress (LOAD through FIN)
//   DONE       one-cycle pulse on normal completion
//   ERR        one-cycle pulse after an illegal START
//   REPS_LEFT  remaining sweeps, including the current one
// ---------------------------------------------------------------------------
module updown_sweep_ctrl #(
    parameter int N     = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic [N-1:0]     LO,
    input  logic [N-1:0]     HI,
    input  logic [REP_W-1:0] REPS,
    input  logic [N-1:0]     CNT,
    output logic             CNTR_RST,
    output logic             CNTR_LD,
    output logic             CNTR_UP,
    output logic [N-1:0]     CNTR_DIN,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [REP_W-1:0] REPS_LEFT
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_UP   = 3'd2;
    localparam logic [2:0] ST_DOWN = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [N-1:0]     ONE_N = {{(N-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] ONE_R = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] ZERO_R = {REP_W{1'b0}};
    localparam logic [N-1:0]     ZERO_N = {N{1'b0}};

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [N-1:0]     lo_q;
    logic [N-1:0]     hi_q;
    logic [REP_W-1:0] reps_q;
    logic             err_r;
    logic             cntr_rst_r;

    logic             start_ok_s;
    logic             start_bad_s;
    logic             up_turn_s;
    logic             down_turn_s;

    // Qualify a START request and detect the turn-around points of a sweep.
    // Turning one count early lets the counter land exactly on hi_q / lo_q
    // on the same edge the state changes, so it never overshoots or wraps.
    always_comb begin
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        if (START && !ABORT) begin
            if ((LO < HI) && (REPS != ZERO_R)) begin
                start_ok_s = 1'b1;
            end else begin
                start_bad_s = 1'b1;
            end
        end else begin
            start_ok_s  = 1'b0;
            start_bad_s = 1'b0;
        end
        up_turn_s   = (CNT == (hi_q - ONE_N));
        down_turn_s = (CNT == (lo_q + ONE_N));
    end

    // Next-state logic; ABORT takes priority in every active state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ABORT) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_UP;
                end
            end
            ST_UP: begin
                if (ABORT) begin
                    next_state_s = ST_IDLE;
                end else if (up_turn_s) begin
                    next_state_s = ST_DOWN;
                end else begin
                    next_state_s = ST_UP;
                end
            end
            ST_DOWN: begin
                if (ABORT) begin
                    next_state_s = ST_IDLE;
                end else if (down_turn_s) begin
                    if (reps_q == ONE_R) begin
                        next_state_s = ST_FIN;
                    end else begin
                        next_state_s = ST_UP;
                    end
                end else begin
                    next_state_s = ST_DOWN;
                end
            end
            ST_FIN: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, latched run parameters and the ERR pulse register.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            lo_q    <= ZERO_N;
            hi_q    <= ZERO_N;
            reps_q  <= ZERO_R;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            err_r   <= (state_r == ST_IDLE) && start_bad_s;
            if ((state_r == ST_IDLE) && start_ok_s) begin
                lo_q   <= LO;
                hi_q   <= HI;
                reps_q <= REPS;
            end else if ((state_r == ST_DOWN) && down_turn_s && !ABORT) begin
                // One sweep completes on the edge the counter returns to lo_q.
                reps_q <= reps_q - ONE_R;
            end else begin
                reps_q <= reps_q;
            end
        end
    end

    // Counter clear: held during reset, dropped on the first edge after it,
    // giving the counter one synchronous clear edge once clk runs freely.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cntr_rst_r <= 1'b1;
        end else begin
            cntr_rst_r <= 1'b0;
        end
    end

    // Moore output decode; the hold value DIN=CNT is a direct passthrough.
    always_comb begin
        CNTR_LD  = 1'b1;
        CNTR_UP  = 1'b0;
        CNTR_DIN = CNT;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                BUSY = 1'b0;
            end
            ST_LOAD: begin
                CNTR_DIN = lo_q;
                BUSY     = 1'b1;
            end
            ST_UP: begin
                CNTR_LD = 1'b0;
                CNTR_UP = 1'b1;
                BUSY    = 1'b1;
            end
            ST_DOWN: begin
                CNTR_LD = 1'b0;
                CNTR_UP = 1'b0;
                BUSY    = 1'b1;
            end
            ST_FIN: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    assign CNTR_RST  = cntr_rst_r;
    assign ERR       = err_r;
    assign REPS_LEFT = reps_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_updown_sweep_ctrl
//
// Directed bench for updown_sweep_ctrl. A behavioural N-bit up/down counter
// sits beside the DUT exactly as the real counter would. All expected values
// are hand-computed constants. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

    localparam int N     = 4;
    localparam int REP_W = 4;

    logic             clk;
    logic             RESET;
    logic             START;
    logic             ABORT;
    logic [N-1:0]     LO;
    logic [N-1:0]     HI;
    logic [REP_W-1:0] REPS;
    logic [N-1:0]     cnt;
    logic             CNTR_RST;
    logic             CNTR_LD;
    logic             CNTR_UP;
    logic [N-1:0]     CNTR_DIN;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [REP_W-1:0] REPS_LEFT;

    int n_cmp  = 0;
    int n_fail = 0;
    int busy_cnt;
    int done_cnt;

    // Hand-computed count sequences (value after each edge from LOAD).
    int seq_basic[13] = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
    int reps_basic[13] = '{2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 0};
    int seq_min[7]    = '{7, 8, 7, 8, 7, 8, 7};
    int seq_top[3]    = '{14, 15, 14};
    int seq_rst[7]    = '{2, 3, 4, 5, 6, 5, 4};
    int seq_new[5]    = '{1, 2, 3, 2, 1};
    // Illegal start table: LO, HI, REPS.
    int bad_lo[3]     = '{5, 6, 1};
    int bad_hi[3]     = '{5, 3, 3};
    int bad_reps[3]   = '{1, 1, 0};

    updown_sweep_ctrl #(.N(N), .REP_W(REP_W)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .START     (START),
        .ABORT     (ABORT),
        .LO        (LO),
        .HI        (HI),
        .REPS      (REPS),
        .CNT       (cnt),
        .CNTR_RST  (CNTR_RST),
        .CNTR_LD   (CNTR_LD),
        .CNTR_UP   (CNTR_UP),
        .CNTR_DIN  (CNTR_DIN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .REPS_LEFT (REPS_LEFT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the external counter: sync clear, load, else count up/down.
    always @(posedge clk) begin
        if (CNTR_RST)
            cnt <= '0;
        else if (CNTR_LD)
            cnt <= CNTR_DIN;
        else if (CNTR_UP)
            cnt <= cnt + 4'd1;
        else
            cnt <= cnt - 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int lo, input int hi, input int reps);
        LO    = lo[N-1:0];
        HI    = hi[N-1:0];
        REPS  = reps[REP_W-1:0];
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        LO    = '0;
        HI    = '0;
        REPS  = '0;

        // ---------------- reset ----------------
        tick(); tick(); tick();
        check("rst_busy", BUSY, 0);
        check("rst_cntr_rst", CNTR_RST, 1);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_reps_left", REPS_LEFT, 0);
        check("rst_cnt", cnt, 0);
        RESET = 1'b0;
        tick();
        check("rel_cntr_rst", CNTR_RST, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_cnt", cnt, 0);
            check("idle_ld", CNTR_LD, 1);
        end

        // ---------------- basic run LO=2 HI=5 REPS=2 ----------------
        start_run(2, 5, 2);
        busy_cnt = 0;
        done_cnt = 0;
        check("load_din", CNTR_DIN, 2);
        check("load_ld", CNTR_LD, 1);
        check("load_reps_left", REPS_LEFT, 2);
        if (BUSY) busy_cnt++;
        for (int i = 0; i < 13; i++) begin
            tick();
            check("basic_cnt", cnt, seq_basic[i]);
            check("basic_reps_left", REPS_LEFT, reps_basic[i]);
            if (BUSY) busy_cnt++;
            if (DONE) done_cnt++;
        end
        check("basic_done_last", DONE, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("basic_hold_cnt", cnt, 2);
            if (BUSY) busy_cnt++;
            if (DONE) done_cnt++;
        end
        check("basic_busy_cycles", busy_cnt, 14);
        check("basic_done_count", done_cnt, 1);
        check("basic_reps_after", REPS_LEFT, 0);

        // ---------------- minimum span LO=7 HI=8 REPS=3 ----------------
        start_run(7, 8, 3);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("min_cnt", cnt, seq_min[i]);
        end
        check("min_done", DONE, 1);
        tick();
        check("min_idle_busy", BUSY, 0);
        check("min_hold", cnt, 7);

        // ---------------- top of range LO=14 HI=15 REPS=1 ----------------
        start_run(14, 15, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("top_cnt", cnt, seq_top[i]);
        end
        check("top_done", DONE, 1);
        tick();
        tick();
        check("top_hold", cnt, 14);

        // ---------------- illegal starts ----------------
        for (int i = 0; i < 3; i++) begin
            start_run(bad_lo[i], bad_hi[i], bad_reps[i]);
            check("bad_err_pulse", ERR, 1);
            check("bad_busy", BUSY, 0);
            tick();
            check("bad_err_clear", ERR, 0);
            check("bad_busy2", BUSY, 0);
            check("bad_cnt", cnt, 14);
            check("bad_reps_left", REPS_LEFT, 0);
        end

        // ---------------- abort LO=0 HI=9 REPS=1 ----------------
        start_run(0, 9, 1);
        for (int i = 0; i < 4; i++) tick();
        check("abort_cnt3", cnt, 3);
        // START mid-run with different parameters must be ignored
        LO = 4'd1; HI = 4'd2; REPS = 4'd5; START = 1'b1;
        tick();
        START = 1'b0;
        check("midstart_cnt", cnt, 4);
        check("midstart_reps", REPS_LEFT, 1);
        tick(); tick();
        check("abort_cnt6", cnt, 6);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_cnt7", cnt, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_frozen", cnt, 7);
            check("abort_no_done", DONE, 0);
        end
        check("abort_reps_kept", REPS_LEFT, 1);

        // START together with ABORT in IDLE: nothing happens
        LO = 4'd1; HI = 4'd4; REPS = 4'd1; START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        check("sa_busy", BUSY, 0);
        check("sa_err", ERR, 0);
        tick();
        check("sa_busy2", BUSY, 0);
        check("sa_cnt", cnt, 7);

        // ---------------- reset mid-run on the down leg ----------------
        start_run(2, 6, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("rr_cnt", cnt, seq_rst[i]);
        end
        check("rr_down_dir", CNTR_UP, 0);
        RESET = 1'b1;
        #1;
        check("rr_busy_async", BUSY, 0);
        check("rr_cntr_rst", CNTR_RST, 1);
        tick();
        check("rr_cnt_clear", cnt, 0);
        RESET = 1'b0;
        tick();
        check("rr_cntr_rst_rel", CNTR_RST, 0);
        check("rr_cnt0", cnt, 0);
        check("rr_reps_left", REPS_LEFT, 0);

        // New run after reset LO=1 HI=3 REPS=1
        start_run(1, 3, 1);
        check("new_busy", BUSY, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("new_cnt", cnt, seq_new[i]);
        end
        check("new_done", DONE, 1);
        tick();
        check("new_idle", BUSY, 0);
        check("new_hold", cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
